// File: rtl/ysyx_24100006_exe_mdu.sv
// Execute stage: single-cycle ALU, iterative RV32M multiply/divide engine and fence.i wait.
// Optional macro EXE_MDU_EARLY_OUT_EN: trivial M ops (x0 operand, /0, overflow, |a|<|b|) finish
// in one cycle. ALU opcodes: 0 ADD 1 SUB 2 SLL 3 SLT 4 SLTU 5 XOR 6 SRL 7 SRA 8 OR 9 AND 10 B.
module ysyx_24100006_exe_mdu #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter int unsigned SB_W           = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [3:0]      alu_op,
  input  logic            src_a_sel,
  input  logic            src_b_sel,
  input  logic            md_en,
  input  logic [2:0]      md_op,
  input  logic            is_fence_i,
  input  logic            icache_flush_done,
  input  logic [SB_W-1:0] sb_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result_o,
  output logic [SB_W-1:0] sb_o,
  output logic            md_busy
);

  localparam int unsigned Iter = XLEN / BITS_PER_CYCLE;
  localparam int unsigned CntW = $clog2(Iter) + 1;
  localparam int unsigned ShW  = $clog2(XLEN);
  localparam logic [CntW-1:0] LastCnt = CntW'(Iter - 1);

  typedef enum logic [1:0] {StIdle, StMdBusy, StFenceWait, StDone} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [SB_W-1:0] sb_q, sb_d;
  logic [XLEN-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [3:0]      alu_op_q, alu_op_d;
  logic [2:0]      md_op_q, md_op_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] acc_q, acc_d, lo_q, lo_d, mc_q, mc_d;
  logic            neg_q, neg_d, rem_neg_q, rem_neg_d, div0_q, div0_d;

  function automatic logic [XLEN-1:0] alu(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                          input logic [3:0] op);
    logic [ShW-1:0] sh;
    sh = b[ShW-1:0];
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a << sh;
      4'd3:    return {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd4:    return {{(XLEN-1){1'b0}}, (a < b)};
      4'd5:    return a ^ b;
      4'd6:    return a >> sh;
      4'd7:    return $unsigned($signed(a) >>> sh);
      4'd8:    return a | b;
      4'd9:    return a & b;
      4'd10:   return b;
      default: return '0;
    endcase
  endfunction

  logic [XLEN-1:0] mux_a, mux_b, a_mag, b_mag;
  logic            a_sgn, b_sgn;

  assign mux_a = src_a_sel ? pc_i : rs1_i;
  assign mux_b = src_b_sel ? imm_i : rs2_i;

  // Operands are treated as signed only where the op needs it; MUL is computed unsigned.
  always_comb begin
    a_sgn = rs1_i[XLEN-1] & ((md_op == 3'd1) | (md_op == 3'd2) | (md_op == 3'd4) |
                             (md_op == 3'd6));
    b_sgn = rs2_i[XLEN-1] & ((md_op == 3'd1) | (md_op == 3'd4) | (md_op == 3'd6));
    a_mag = a_sgn ? -rs1_i : rs1_i;
    b_mag = b_sgn ? -rs2_i : rs2_i;
  end

  logic            early;
  logic [XLEN-1:0] early_res;

`ifdef EXE_MDU_EARLY_OUT_EN
  always_comb begin
    early     = 1'b0;
    early_res = '0;
    if (md_op[2]) begin
      if (rs2_i == '0) begin
        early     = 1'b1;
        early_res = md_op[1] ? rs1_i : '1;
      end else if (a_sgn && b_sgn && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1)) begin
        early     = 1'b1;
        early_res = md_op[1] ? '0 : rs1_i;
      end else if (a_mag < b_mag) begin
        early     = 1'b1;
        early_res = md_op[1] ? rs1_i : '0;
      end
    end else if ((rs1_i == '0) || (rs2_i == '0)) begin
      early     = 1'b1;
      early_res = '0;
    end
  end
`else
  assign early     = 1'b0;
  assign early_res = '0;
`endif

  // One engine step: BITS_PER_CYCLE shift-add (multiply) or restoring-subtract (divide) bits.
  logic [XLEN-1:0] acc_it, lo_it;
  logic [XLEN:0]   sum;

  always_comb begin
    acc_it = acc_q;
    lo_it  = lo_q;
    sum    = '0;
    for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
      if (md_op_q[2]) begin
        sum = {acc_it, lo_it[XLEN-1]} - {1'b0, mc_q};
        if (!sum[XLEN]) begin
          acc_it = sum[XLEN-1:0];
          lo_it  = {lo_it[XLEN-2:0], 1'b1};
        end else begin
          acc_it = {acc_it[XLEN-2:0], lo_it[XLEN-1]};
          lo_it  = {lo_it[XLEN-2:0], 1'b0};
        end
      end else begin
        sum    = {1'b0, acc_it} + (lo_it[0] ? {1'b0, mc_q} : '0);
        acc_it = sum[XLEN:1];
        lo_it  = {sum[0], lo_it[XLEN-1:1]};
      end
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, md_res;

  always_comb begin
    prod = {acc_it, lo_it};
    if (neg_q) prod = -prod;
    quo = neg_q ? -lo_it : lo_it;
    rem = rem_neg_q ? -acc_it : acc_it;
    if (div0_q) begin
      quo = '1;
      rem = op_a_q;
    end
    case (md_op_q)
      3'd0:             md_res = prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3: md_res = prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:       md_res = quo;
      default:          md_res = rem;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    sb_d      = sb_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    alu_op_d  = alu_op_q;
    md_op_d   = md_op_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    lo_d      = lo_q;
    mc_d      = mc_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          sb_d     = sb_i;
          alu_op_d = alu_op;
          md_op_d  = md_op;
          cnt_d    = '0;
          if (is_fence_i) begin
            op_a_d  = mux_a;
            op_b_d  = mux_b;
            state_d = StFenceWait;
          end else if (md_en) begin
            op_a_d    = rs1_i;
            op_b_d    = rs2_i;
            acc_d     = '0;
            lo_d      = a_mag;
            mc_d      = b_mag;
            neg_d     = a_sgn ^ b_sgn;
            rem_neg_d = a_sgn;
            div0_d    = md_op[2] & (rs2_i == '0);
            if (early) begin
              result_d = early_res;
              state_d  = StDone;
            end else begin
              state_d = StMdBusy;
            end
          end else begin
            op_a_d   = mux_a;
            op_b_d   = mux_b;
            result_d = alu(mux_a, mux_b, alu_op);
            state_d  = StDone;
          end
        end
      end
      StMdBusy: begin
        acc_d = acc_it;
        lo_d  = lo_it;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          result_d = md_res;
          state_d  = StDone;
        end
      end
      StFenceWait: begin
        if (icache_flush_done) begin
          result_d = alu(op_a_q, op_b_q, alu_op_q);
          state_d  = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      result_q  <= '0;
      sb_q      <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      alu_op_q  <= '0;
      md_op_q   <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      lo_q      <= '0;
      mc_q      <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      sb_q      <= sb_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      alu_op_q  <= alu_op_d;
      md_op_q   <= md_op_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      lo_q      <= lo_d;
      mc_q      <= mc_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign md_busy   = (state_q == StMdBusy);
  assign result_o  = result_q;
  assign sb_o      = sb_q;

endmodule
